// File: rtl/ascon_round_downcounter.sv
// ascon_round_downcounter
// Loadable down-counter that sequences a programmed number of ASCON
// permutation rounds. start_i arms it with cnt_i, each en_i tick in RUN
// steps the count down, and the tick taken at zero ends the sequence with
// a one-cycle done_o pulse.
// Optional feature macro: ASCON_ROUND_DOWNCNT_RELOAD_EN adds reload_i.
// When reload_i is high on the final tick, the counter re-arms from the
// value latched at start (rld_q) and stays in RUN.
module ascon_round_downcounter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             en_i,
  input  logic             abort_i,
`ifdef ASCON_ROUND_DOWNCNT_RELOAD_EN
  input  logic             reload_i,
`endif
  output logic [WIDTH-1:0] cnt_o,
  output logic             busy_o,
  output logic             last_o,
  output logic             done_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             final_tick;

`ifdef ASCON_ROUND_DOWNCNT_RELOAD_EN
  logic [WIDTH-1:0] rld_q, rld_d;
`endif

  // A tick taken while the count is already zero ends the sequence.
  assign final_tick = (state_q == RUN) && en_i && (cnt_q == '0);

  // State, count and done registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef ASCON_ROUND_DOWNCNT_RELOAD_EN
      rld_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef ASCON_ROUND_DOWNCNT_RELOAD_EN
      rld_q   <= rld_d;
`endif
    end
  end

  // Next-state: abort beats start, start beats a tick. A start on the
  // final tick restarts the sequence and swallows that done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef ASCON_ROUND_DOWNCNT_RELOAD_EN
    rld_d   = rld_q;
`endif
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (start_i) begin
      state_d = RUN;
      cnt_d   = cnt_i;
`ifdef ASCON_ROUND_DOWNCNT_RELOAD_EN
      rld_d   = cnt_i;
`endif
    end else if (final_tick) begin
      done_d = 1'b1;
`ifdef ASCON_ROUND_DOWNCNT_RELOAD_EN
      if (reload_i) begin
        cnt_d = rld_q;
      end else begin
        state_d = IDLE;
      end
`else
      state_d = IDLE;
`endif
    end else if ((state_q == RUN) && en_i) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (state_q == RUN);
  assign last_o = busy_o && (cnt_q == '0);
  assign done_o = done_q;

endmodule
